// File: rtl/alu_share_arbiter_if.sv
// Bundle of both requester channels (request + response) and the ALU-side
// signals shared between the arbiter and its surroundings.
interface alu_share_arbiter_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int OPCODE_LENGTH   = 4,
    parameter int STALL_CNT_WIDTH = 16
);
    // Requester 0 (execute path)
    logic                     req0_valid;
    logic                     req0_ready;
    logic [DATA_WIDTH-1:0]    req0_srca;
    logic [DATA_WIDTH-1:0]    req0_srcb;
    logic [OPCODE_LENGTH-1:0] req0_op;
    logic [3:0]               req0_brflags;
    logic                     rsp0_valid;
    logic                     rsp0_ready;
    logic [DATA_WIDTH-1:0]    rsp0_result;

    // Requester 1 (branch/address-compare path)
    logic                     req1_valid;
    logic                     req1_ready;
    logic [DATA_WIDTH-1:0]    req1_srca;
    logic [DATA_WIDTH-1:0]    req1_srcb;
    logic [OPCODE_LENGTH-1:0] req1_op;
    logic [3:0]               req1_brflags;
    logic                     rsp1_valid;
    logic                     rsp1_ready;
    logic [DATA_WIDTH-1:0]    rsp1_result;

    // Shared ALU
    logic [DATA_WIDTH-1:0]    alu_srca;
    logic [DATA_WIDTH-1:0]    alu_srcb;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic                     alu_blt;
    logic                     alu_bgt;
    logic                     alu_bltu;
    logic                     alu_bgeu;
    logic [DATA_WIDTH-1:0]    alu_result;

    // Status
    logic                       alu_busy;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt;

    // Requesters and ALU side
    modport master (
        output req0_valid, req0_srca, req0_srcb, req0_op, req0_brflags, rsp0_ready,
        output req1_valid, req1_srca, req1_srcb, req1_op, req1_brflags, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_result,
        input  req1_ready, rsp1_valid, rsp1_result,
        input  alu_srca, alu_srcb, alu_op, alu_blt, alu_bgt, alu_bltu, alu_bgeu,
        output alu_result,
        input  alu_busy, stall_cnt
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_srca, req0_srcb, req0_op, req0_brflags, rsp0_ready,
        input  req1_valid, req1_srca, req1_srcb, req1_op, req1_brflags, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_result,
        output req1_ready, rsp1_valid, rsp1_result,
        output alu_srca, alu_srcb, alu_op, alu_blt, alu_bgt, alu_bltu, alu_bgeu,
        input  alu_result,
        output alu_busy, stall_cnt
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between the execute path
// (requester 0) and the branch-compare path (requester 1). One registered
// issue stage feeds the ALU; each requester owns one response register and
// may have at most one operation in flight.
module alu_share_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int OPCODE_LENGTH   = 4,
    parameter int STALL_CNT_WIDTH = 16
) (
    input logic              clk,
    input logic              reset,
    alu_share_arbiter_if.slave bus
);

    localparam logic [OPCODE_LENGTH-1:0]   OP_IDLE = '1;
    localparam logic [STALL_CNT_WIDTH-1:0] CNT_ONE = STALL_CNT_WIDTH'(1);

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(
        input logic [STALL_CNT_WIDTH-1:0] v
    );
        if (&v) begin
            return v;
        end
        return v + CNT_ONE;
    endfunction

    // Control state
    logic                       pending0_q, pending0_d;
    logic                       pending1_q, pending1_d;
    logic                       prio_q, prio_d;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    // Issue stage (p1)
    logic                     vld_p1_q, vld_p1_d;
    logic                     id_p1_q, id_p1_d;
    logic [DATA_WIDTH-1:0]    srca_p1_q, srca_p1_d;
    logic [DATA_WIDTH-1:0]    srcb_p1_q, srcb_p1_d;
    logic [OPCODE_LENGTH-1:0] op_p1_q, op_p1_d;
    logic [3:0]               brflags_p1_q, brflags_p1_d;

    // Response stage (p2), one register per requester
    logic                  rsp0_vld_p2_q, rsp0_vld_p2_d;
    logic [DATA_WIDTH-1:0] rsp0_result_p2_q, rsp0_result_p2_d;
    logic                  rsp1_vld_p2_q, rsp1_vld_p2_d;
    logic [DATA_WIDTH-1:0] rsp1_result_p2_q, rsp1_result_p2_d;

    logic rsp0_hs, rsp1_hs;
    logic elig0, elig1;
    logic grant0, grant1;

    // Arbitration: a requester may issue when its previous result is gone or
    // is being consumed this cycle, so the response register is never overrun.
    always_comb begin
        rsp0_hs = rsp0_vld_p2_q && bus.rsp0_ready;
        rsp1_hs = rsp1_vld_p2_q && bus.rsp1_ready;
        elig0   = bus.req0_valid && (!pending0_q || rsp0_hs);
        elig1   = bus.req1_valid && (!pending1_q || rsp1_hs);
        grant0  = elig0 && (!elig1 || !prio_q);
        grant1  = elig1 && (!elig0 ||  prio_q);
    end

    // Next-state for control, issue stage and response registers
    always_comb begin
        pending0_d       = pending0_q;
        pending1_d       = pending1_q;
        prio_d           = prio_q;
        stall_cnt_d      = stall_cnt_q;
        vld_p1_d         = grant0 || grant1;
        id_p1_d          = id_p1_q;
        srca_p1_d        = srca_p1_q;
        srcb_p1_d        = srcb_p1_q;
        op_p1_d          = op_p1_q;
        brflags_p1_d     = brflags_p1_q;
        rsp0_vld_p2_d    = rsp0_vld_p2_q;
        rsp0_result_p2_d = rsp0_result_p2_q;
        rsp1_vld_p2_d    = rsp1_vld_p2_q;
        rsp1_result_p2_d = rsp1_result_p2_q;

        // Outstanding tracking: a new accept wins over a same-cycle handshake
        if (grant0) begin
            pending0_d = 1'b1;
        end else if (rsp0_hs) begin
            pending0_d = 1'b0;
        end
        if (grant1) begin
            pending1_d = 1'b1;
        end else if (rsp1_hs) begin
            pending1_d = 1'b0;
        end

        // Priority passes to the other requester after every grant
        if (grant0) begin
            prio_d = 1'b1;
        end else if (grant1) begin
            prio_d = 1'b0;
        end

        // Load the issue stage from the winner; otherwise keep the old payload
        if (grant0) begin
            id_p1_d      = 1'b0;
            srca_p1_d    = bus.req0_srca;
            srcb_p1_d    = bus.req0_srcb;
            op_p1_d      = bus.req0_op;
            brflags_p1_d = bus.req0_brflags;
        end else if (grant1) begin
            id_p1_d      = 1'b1;
            srca_p1_d    = bus.req1_srca;
            srcb_p1_d    = bus.req1_srcb;
            op_p1_d      = bus.req1_op;
            brflags_p1_d = bus.req1_brflags;
        end

        // Capture the ALU result for the owner of the issued op
        if (vld_p1_q && !id_p1_q) begin
            rsp0_vld_p2_d    = 1'b1;
            rsp0_result_p2_d = bus.alu_result;
        end else if (rsp0_hs) begin
            rsp0_vld_p2_d = 1'b0;
        end
        if (vld_p1_q && id_p1_q) begin
            rsp1_vld_p2_d    = 1'b1;
            rsp1_result_p2_d = bus.alu_result;
        end else if (rsp1_hs) begin
            rsp1_vld_p2_d = 1'b0;
        end

        // Contention: any valid request left waiting this cycle
        if ((bus.req0_valid && !grant0) || (bus.req1_valid && !grant1)) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    // State registers; reset discards in-flight work and all results
    always_ff @(posedge clk) begin
        if (reset) begin
            pending0_q       <= 1'b0;
            pending1_q       <= 1'b0;
            prio_q           <= 1'b0;
            stall_cnt_q      <= '0;
            vld_p1_q         <= 1'b0;
            id_p1_q          <= 1'b0;
            srca_p1_q        <= '0;
            srcb_p1_q        <= '0;
            op_p1_q          <= '0;
            brflags_p1_q     <= '0;
            rsp0_vld_p2_q    <= 1'b0;
            rsp0_result_p2_q <= '0;
            rsp1_vld_p2_q    <= 1'b0;
            rsp1_result_p2_q <= '0;
        end else begin
            pending0_q       <= pending0_d;
            pending1_q       <= pending1_d;
            prio_q           <= prio_d;
            stall_cnt_q      <= stall_cnt_d;
            vld_p1_q         <= vld_p1_d;
            id_p1_q          <= id_p1_d;
            srca_p1_q        <= srca_p1_d;
            srcb_p1_q        <= srcb_p1_d;
            op_p1_q          <= op_p1_d;
            brflags_p1_q     <= brflags_p1_d;
            rsp0_vld_p2_q    <= rsp0_vld_p2_d;
            rsp0_result_p2_q <= rsp0_result_p2_d;
            rsp1_vld_p2_q    <= rsp1_vld_p2_d;
            rsp1_result_p2_q <= rsp1_result_p2_d;
        end
    end

    // ALU drive: idle pattern whenever the issue stage is empty
    always_comb begin
        bus.alu_srca = '0;
        bus.alu_srcb = '0;
        bus.alu_op   = OP_IDLE;
        bus.alu_blt  = 1'b0;
        bus.alu_bgt  = 1'b0;
        bus.alu_bltu = 1'b0;
        bus.alu_bgeu = 1'b0;
        if (vld_p1_q) begin
            bus.alu_srca = srca_p1_q;
            bus.alu_srcb = srcb_p1_q;
            bus.alu_op   = op_p1_q;
            bus.alu_blt  = brflags_p1_q[3];
            bus.alu_bgt  = brflags_p1_q[2];
            bus.alu_bltu = brflags_p1_q[1];
            bus.alu_bgeu = brflags_p1_q[0];
        end
    end

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.rsp0_valid  = rsp0_vld_p2_q;
    assign bus.rsp0_result = rsp0_result_p2_q;
    assign bus.rsp1_valid  = rsp1_vld_p2_q;
    assign bus.rsp1_result = rsp1_result_p2_q;
    assign bus.alu_busy    = vld_p1_q;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU.
module tb_alu_share_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int SW = 4;

    logic clk;
    logic reset;

    int n_cmp;
    int n_bad;

    alu_share_arbiter_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .STALL_CNT_WIDTH(SW)) bus ();

    alu_share_arbiter #(
        .DATA_WIDTH(DW),
        .OPCODE_LENGTH(OW),
        .STALL_CNT_WIDTH(SW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: AND/OR/ADD/SUB, and a branch compare (op 1001) that
    // returns 0 when the selected condition holds, 1 when it does not.
    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_op)
            4'b0000: bus.alu_result = bus.alu_srca & bus.alu_srcb;
            4'b0001: bus.alu_result = bus.alu_srca | bus.alu_srcb;
            4'b0010: bus.alu_result = bus.alu_srca + bus.alu_srcb;
            4'b0110: bus.alu_result = bus.alu_srca - bus.alu_srcb;
            4'b1001: begin
                if (bus.alu_blt)
                    bus.alu_result = ($signed(bus.alu_srca) < $signed(bus.alu_srcb)) ? 32'd0 : 32'd1;
                else if (bus.alu_bgt)
                    bus.alu_result = ($signed(bus.alu_srca) > $signed(bus.alu_srcb)) ? 32'd0 : 32'd1;
                else if (bus.alu_bltu)
                    bus.alu_result = (bus.alu_srca < bus.alu_srcb) ? 32'd0 : 32'd1;
                else if (bus.alu_bgeu)
                    bus.alu_result = (bus.alu_srca >= bus.alu_srcb) ? 32'd0 : 32'd1;
                else
                    bus.alu_result = 32'd0;
            end
            default: bus.alu_result = '0;
        endcase
    end

    typedef struct {
        int          rq;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [3:0]  fl;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int rq, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op, input logic [3:0] fl);
        if (rq == 0) begin
            bus.req0_valid = v; bus.req0_srca = a; bus.req0_srcb = b;
            bus.req0_op = op; bus.req0_brflags = fl;
        end else begin
            bus.req1_valid = v; bus.req1_srca = a; bus.req1_srcb = b;
            bus.req1_op = op; bus.req1_brflags = fl;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One isolated transaction: accept, issue, response, handshake.
    task automatic run_vec(input int idx);
        vec_t v;
        logic rdy, rv;
        logic [31:0] res;
        v = vecs[idx];
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        set_req(v.rq, 1'b1, v.a, v.b, v.op, v.fl);
        #1;
        rdy = (v.rq == 0) ? bus.req0_ready : bus.req1_ready;
        check($sformatf("vec%0d ready", idx), {63'd0, rdy}, 64'd1);
        tick();
        set_req(v.rq, 1'b0, v.a, v.b, v.op, v.fl);
        #1;
        check($sformatf("vec%0d busy", idx), {63'd0, bus.alu_busy}, 64'd1);
        check($sformatf("vec%0d alu_op", idx), {60'd0, bus.alu_op}, {60'd0, v.op});
        check($sformatf("vec%0d alu_srca", idx), {32'd0, bus.alu_srca}, {32'd0, v.a});
        check($sformatf("vec%0d alu_srcb", idx), {32'd0, bus.alu_srcb}, {32'd0, v.b});
        check($sformatf("vec%0d alu_flags", idx),
              {60'd0, bus.alu_blt, bus.alu_bgt, bus.alu_bltu, bus.alu_bgeu}, {60'd0, v.fl});
        tick();
        rv  = (v.rq == 0) ? bus.rsp0_valid : bus.rsp1_valid;
        res = (v.rq == 0) ? bus.rsp0_result : bus.rsp1_result;
        check($sformatf("vec%0d rsp_valid", idx), {63'd0, rv}, 64'd1);
        check($sformatf("vec%0d result", idx), {32'd0, res}, {32'd0, v.exp});
        check($sformatf("vec%0d busy_off", idx), {63'd0, bus.alu_busy}, 64'd0);
        tick();
        rv = (v.rq == 0) ? bus.rsp0_valid : bus.rsp1_valid;
        check($sformatf("vec%0d rsp_clear", idx), {63'd0, rv}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.req0_valid = 0; bus.req0_srca = 0; bus.req0_srcb = 0; bus.req0_op = 0; bus.req0_brflags = 0;
        bus.req1_valid = 0; bus.req1_srca = 0; bus.req1_srcb = 0; bus.req1_op = 0; bus.req1_brflags = 0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;

        vecs[0] = '{0, 32'd5,        32'd7,      4'b0010, 4'b0000, 32'd12};
        vecs[1] = '{0, 32'h0000F0F0, 32'h0000FF00, 4'b0000, 4'b0000, 32'h0000F000};
        vecs[2] = '{1, 32'd10,       32'd3,      4'b0110, 4'b0000, 32'd7};
        vecs[3] = '{1, 32'hFFFFFFFF, 32'd1,      4'b1001, 4'b1000, 32'd0};
        vecs[4] = '{1, 32'hFFFFFFFF, 32'd1,      4'b1001, 4'b0000, 32'd0};
        vecs[5] = '{0, 32'h12,       32'h01,     4'b0001, 4'b0000, 32'h13};
        vecs[6] = '{1, 32'd3,        32'd5,      4'b1001, 4'b0010, 32'd0};
        vecs[7] = '{0, 32'd1,        32'd2,      4'b0111, 4'b0000, 32'd0};
        vecs[8] = '{0, 32'd1,        32'd5,      4'b1001, 4'b0100, 32'd1};
        vecs[9] = '{1, 32'hFFFFFFFF, 32'd1,      4'b1001, 4'b0001, 32'd0};

        do_reset();

        // Reset state
        check("rst rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd0);
        check("rst rsp1_valid", {63'd0, bus.rsp1_valid}, 64'd0);
        check("rst rsp0_result", {32'd0, bus.rsp0_result}, 64'd0);
        check("rst rsp1_result", {32'd0, bus.rsp1_result}, 64'd0);
        check("rst alu_op", {60'd0, bus.alu_op}, 64'hF);
        check("rst alu_srca", {32'd0, bus.alu_srca}, 64'd0);
        check("rst alu_busy", {63'd0, bus.alu_busy}, 64'd0);
        check("rst stall_cnt", {60'd0, bus.stall_cnt}, 64'd0);

        // Table of isolated transactions
        for (int i = 0; i < 10; i++) begin
            run_vec(i);
        end

        // Contention right after reset
        do_reset();
        set_req(0, 1'b1, 32'h0000F0F0, 32'h0000FF00, 4'b0000, 4'b0000);
        set_req(1, 1'b1, 32'd10, 32'd3, 4'b0110, 4'b0000);
        #1;
        check("cont c0 req0_ready", {63'd0, bus.req0_ready}, 64'd1);
        check("cont c0 req1_ready", {63'd0, bus.req1_ready}, 64'd0);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        check("cont c1 req1_ready", {63'd0, bus.req1_ready}, 64'd1);
        check("cont c1 stall_cnt", {60'd0, bus.stall_cnt}, 64'd1);
        tick();
        bus.req1_valid = 1'b0;
        check("cont c2 rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd1);
        check("cont c2 rsp0_result", {32'd0, bus.rsp0_result}, 64'h0000F000);
        check("cont c2 rsp1_valid", {63'd0, bus.rsp1_valid}, 64'd0);
        tick();
        check("cont c3 rsp1_valid", {63'd0, bus.rsp1_valid}, 64'd1);
        check("cont c3 rsp1_result", {32'd0, bus.rsp1_result}, 64'd7);
        check("cont c3 stall_cnt", {60'd0, bus.stall_cnt}, 64'd1);
        tick();

        // Response backpressure on requester 0
        do_reset();
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b1;
        set_req(0, 1'b1, 32'd5, 32'd7, 4'b0010, 4'b0000);
        #1;
        check("bp c0 req0_ready", {63'd0, bus.req0_ready}, 64'd1);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        check("bp c2 rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd1);
        check("bp c2 rsp0_result", {32'd0, bus.rsp0_result}, 64'd12);
        set_req(0, 1'b1, 32'd9, 32'd4, 4'b0110, 4'b0000);
        set_req(1, 1'b1, 32'd1, 32'd1, 4'b0010, 4'b0000);
        #1;
        check("bp c2 req0_ready", {63'd0, bus.req0_ready}, 64'd0);
        check("bp c2 req1_ready", {63'd0, bus.req1_ready}, 64'd1);
        tick();
        check("bp c3 req0_ready", {63'd0, bus.req0_ready}, 64'd0);
        check("bp c3 req1_ready", {63'd0, bus.req1_ready}, 64'd0);
        check("bp c3 rsp0_result", {32'd0, bus.rsp0_result}, 64'd12);
        tick();
        check("bp c4 req1_ready", {63'd0, bus.req1_ready}, 64'd1);
        check("bp c4 req0_ready", {63'd0, bus.req0_ready}, 64'd0);
        check("bp c4 rsp1_result", {32'd0, bus.rsp1_result}, 64'd2);
        tick();
        bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b1;
        #1;
        check("bp c5 req0_ready", {63'd0, bus.req0_ready}, 64'd1);
        check("bp c5 rsp0_result", {32'd0, bus.rsp0_result}, 64'd12);
        tick();
        bus.req0_valid = 1'b0;
        check("bp c6 rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd0);
        tick();
        check("bp c7 rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd1);
        check("bp c7 rsp0_result", {32'd0, bus.rsp0_result}, 64'd5);
        tick();

        // Round-robin with both requesters always busy
        do_reset();
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        set_req(0, 1'b1, 32'd2, 32'd3, 4'b0010, 4'b0000);
        set_req(1, 1'b1, 32'd8, 32'd1, 4'b0110, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("rr c%0d req0_ready", i), {63'd0, bus.req0_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
            check($sformatf("rr c%0d req1_ready", i), {63'd0, bus.req1_ready}, (i % 2 == 1) ? 64'd1 : 64'd0);
            if (i >= 1) begin
                check($sformatf("rr c%0d busy", i), {63'd0, bus.alu_busy}, 64'd1);
            end
            if (i >= 2) begin
                check($sformatf("rr c%0d rsp_result", i),
                      {32'd0, (i % 2 == 0) ? bus.rsp0_result : bus.rsp1_result},
                      (i % 2 == 0) ? 64'd5 : 64'd7);
            end
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        tick();

        // Stall counter saturation
        do_reset();
        bus.rsp0_ready = 1'b0;
        set_req(0, 1'b1, 32'd5, 32'd7, 4'b0010, 4'b0000);
        tick();
        check("sat c1 stall_cnt", {60'd0, bus.stall_cnt}, 64'd0);
        repeat (10) tick();
        check("sat 10 stall_cnt", {60'd0, bus.stall_cnt}, 64'd10);
        repeat (10) tick();
        check("sat 20 stall_cnt", {60'd0, bus.stall_cnt}, 64'd15);
        repeat (3) tick();
        check("sat hold stall_cnt", {60'd0, bus.stall_cnt}, 64'd15);
        check("sat rsp0_result", {32'd0, bus.rsp0_result}, 64'd12);

        // Reset while an op sits in the issue stage
        do_reset();
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        set_req(1, 1'b1, 32'd4, 32'd4, 4'b0010, 4'b0000);
        #1;
        check("mid req1_ready", {63'd0, bus.req1_ready}, 64'd1);
        tick();
        bus.req1_valid = 1'b0;
        check("mid busy", {63'd0, bus.alu_busy}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd0);
        check("mid rsp1_valid", {63'd0, bus.rsp1_valid}, 64'd0);
        check("mid stall_cnt", {60'd0, bus.stall_cnt}, 64'd0);
        check("mid busy_off", {63'd0, bus.alu_busy}, 64'd0);
        check("mid alu_op", {60'd0, bus.alu_op}, 64'hF);
        tick();
        check("mid late rsp1_valid", {63'd0, bus.rsp1_valid}, 64'd0);
        tick();
        check("mid late2 rsp1_valid", {63'd0, bus.rsp1_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
